// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg: shared VGA 640x480@60 timing constants, counter width, sync
// polarity, the registered control-bit bundle and a line/frame total helper.
// No ports.
// -----------------------------------------------------------------------------
package vga_pkg;

   localparam int unsigned CNT_W        = 10;

   // Horizontal timing, in pixels
   localparam int unsigned H_ACTIVE_DEF = 640;
   localparam int unsigned H_FP         = 16;
   localparam int unsigned H_SYNC       = 96;
   localparam int unsigned H_BP         = 48;
   localparam int unsigned H_TOTAL      = 800;

   // Vertical timing, in lines
   localparam int unsigned V_ACTIVE_DEF = 480;
   localparam int unsigned V_FP         = 10;
   localparam int unsigned V_SYNC       = 2;
   localparam int unsigned V_BP         = 33;
   localparam int unsigned V_TOTAL      = 525;

   // Both syncs are active-low
   localparam logic        SYNC_ACTIVE  = 1'b0;

   // Control outputs decoded from the counters and registered together
   typedef struct packed {
      logic visible;
      logic hsync;
      logic vsync;
   } vga_ctl_t;

   localparam vga_ctl_t CTL_RESET = '{visible: 1'b0,
                                      hsync:   ~SYNC_ACTIVE,
                                      vsync:   ~SYNC_ACTIVE};

   function automatic int unsigned span_total(input int unsigned active,
                                              input int unsigned fp,
                                              input int unsigned sync,
                                              input int unsigned bp);
      return active + fp + sync + bp;
   endfunction

endpackage

// File: rtl/wrap_counter.sv
// -----------------------------------------------------------------------------
// wrap_counter: enabled up-counter that wraps from MAX back to 0.
// Ports:
//   clk, rst          clock, async active-high reset
//   i_en              advance by one this cycle
//   o_count           registered count
//   o_count_nxt_c     value the count takes at the next edge (combinational)
//   o_wrap_c          high when this edge wraps MAX -> 0 (combinational)
// -----------------------------------------------------------------------------
module wrap_counter
   import vga_pkg::*;
#(
   parameter int unsigned MAX = H_TOTAL - 1,
   parameter int unsigned W   = CNT_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_en,
   output logic [W-1:0] o_count,
   output logic [W-1:0] o_count_nxt_c,
   output logic         o_wrap_c
);

   logic [W-1:0] r_count;
   logic         w_at_max;

   assign w_at_max = (r_count == W'(MAX));
   assign o_wrap_c = i_en & w_at_max;
   assign o_count  = r_count;

   // Next-value logic, exported so the parent can decode ahead of the edge
   always_comb begin
      o_count_nxt_c = r_count;
      if (i_en) begin
         o_count_nxt_c = w_at_max ? '0 : r_count + W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else begin
         r_count <= o_count_nxt_c;
      end
   end

endmodule

// File: rtl/vga_timing.sv
// -----------------------------------------------------------------------------
// vga_timing: VGA raster timing generator, 50 MHz clk with a 25 MHz pixel
// enable. Horizontal and vertical positions come from two wrap_counters;
// visible/hsync/vsync are decoded from the counters' next values and
// registered on the same edge, so all position/control outputs move together.
// Ports:
//   clk, rst      50 MHz clock, async active-high reset
//   x, y          current pixel column / line
//   visible       (x,y) inside the active area
//   hsync, vsync  active-low syncs
//   pix_en        pixel enable, high every other clk cycle
//   frame_start   one-clk pulse when the raster returns to (0,0)
// -----------------------------------------------------------------------------
module vga_timing
   import vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
   parameter int unsigned V_ACTIVE = V_ACTIVE_DEF
) (
   input  logic             clk,
   input  logic             rst,
   output logic [CNT_W-1:0] x,
   output logic [CNT_W-1:0] y,
   output logic             visible,
   output logic             hsync,
   output logic             vsync,
   output logic             pix_en,
   output logic             frame_start
);

   localparam int unsigned HT     = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int unsigned VT     = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam int unsigned HS_BEG = H_ACTIVE + H_FP;
   localparam int unsigned HS_END = HS_BEG + H_SYNC - 1;
   localparam int unsigned VS_BEG = V_ACTIVE + V_FP;
   localparam int unsigned VS_END = VS_BEG + V_SYNC - 1;

   logic             r_pix_en;
   logic             r_frame_start;
   vga_ctl_t         r_ctl;
   vga_ctl_t         w_ctl_nxt;
   logic [CNT_W-1:0] w_h;
   logic [CNT_W-1:0] w_v;
   logic [CNT_W-1:0] w_h_nxt;
   logic [CNT_W-1:0] w_v_nxt;
   logic             w_h_wrap;
   logic             w_v_wrap;

   wrap_counter #(.MAX(HT - 1), .W(CNT_W)) u_hcnt (
      .clk          (clk),
      .rst          (rst),
      .i_en         (r_pix_en),
      .o_count      (w_h),
      .o_count_nxt_c(w_h_nxt),
      .o_wrap_c     (w_h_wrap)
   );

   // Lines advance only on the pixel edge that wraps the line
   wrap_counter #(.MAX(VT - 1), .W(CNT_W)) u_vcnt (
      .clk          (clk),
      .rst          (rst),
      .i_en         (w_h_wrap),
      .o_count      (w_v),
      .o_count_nxt_c(w_v_nxt),
      .o_wrap_c     (w_v_wrap)
   );

   // Decode from next counter values; hold between pixel edges so the
   // post-reset pixel (0,0) stays blanked until the first advance.
   always_comb begin
      w_ctl_nxt = r_ctl;
      if (r_pix_en) begin
         w_ctl_nxt.visible = (w_h_nxt < CNT_W'(H_ACTIVE)) &&
                             (w_v_nxt < CNT_W'(V_ACTIVE));
         w_ctl_nxt.hsync   = ((w_h_nxt >= CNT_W'(HS_BEG)) &&
                              (w_h_nxt <= CNT_W'(HS_END))) ? SYNC_ACTIVE
                                                           : ~SYNC_ACTIVE;
         w_ctl_nxt.vsync   = ((w_v_nxt >= CNT_W'(VS_BEG)) &&
                              (w_v_nxt <= CNT_W'(VS_END))) ? SYNC_ACTIVE
                                                           : ~SYNC_ACTIVE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pix_en      <= 1'b0;
         r_ctl         <= CTL_RESET;
         r_frame_start <= 1'b0;
      end else begin
         r_pix_en      <= ~r_pix_en;
         r_ctl         <= w_ctl_nxt;
         // Only a full-frame wrap raises it; reset to (0,0) never does
         r_frame_start <= w_v_wrap;
      end
   end

   assign x           = w_h;
   assign y           = w_v;
   assign visible     = r_ctl.visible;
   assign hsync       = r_ctl.hsync;
   assign vsync       = r_ctl.vsync;
   assign pix_en      = r_pix_en;
   assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing.sv
// -----------------------------------------------------------------------------
// tb_vga_timing: default-size instance plus a reduced-raster instance (so full
// frames fit in a short run), both checked every clk against a closed-form
// model of the raster derived from the number of clk edges since reset.
// -----------------------------------------------------------------------------
module tb_vga_timing;

   localparam int SHA = 64;
   localparam int SVA = 8;

   logic       clk;
   logic       rst;

   logic [9:0] d_x, d_y, s_x, s_y;
   logic       d_vis, d_hs, d_vs, d_pe, d_fs;
   logic       s_vis, s_hs, s_vs, s_pe, s_fs;

   int checks   = 0;
   int failures = 0;
   int n        = 0;   // clk edges seen since reset release

   vga_timing dut_d (
      .clk(clk), .rst(rst), .x(d_x), .y(d_y), .visible(d_vis),
      .hsync(d_hs), .vsync(d_vs), .pix_en(d_pe), .frame_start(d_fs)
   );

   vga_timing #(.H_ACTIVE(SHA), .V_ACTIVE(SVA)) dut_s (
      .clk(clk), .rst(rst), .x(s_x), .y(s_y), .visible(s_vis),
      .hsync(s_hs), .vsync(s_vs), .pix_en(s_pe), .frame_start(s_fs)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (edge %0d, t=%0t)",
                  tag, obs, exp, n, $time);
      end
   endtask

   // Raster after n edges: every second edge is one pixel step; positions
   // are the step count taken modulo the frame size.
   task automatic model_check(input string nm, input int ha, input int va,
                              input logic [9:0] ax, input logic [9:0] ay,
                              input logic av, input logic ah,
                              input logic avs, input logic ape,
                              input logic afs);
      int ht, vt, adv, p, ex, ey;
      logic ev, eh, evs, epe, efs;
      ht  = ha + 16 + 96 + 48;
      vt  = va + 10 + 2 + 33;
      adv = n / 2;
      p   = adv % (ht * vt);
      ex  = p % ht;
      ey  = p / ht;
      ev  = (adv != 0) && (ex < ha) && (ey < va);
      eh  = !((ex >= ha + 16) && (ex <= ha + 16 + 95));
      evs = !((ey >= va + 10) && (ey <= va + 11));
      epe = (n % 2) == 1;
      efs = ((n % 2) == 0) && (adv != 0) && (p == 0);
      check({nm, ".x"},           32'(ax),  32'(ex));
      check({nm, ".y"},           32'(ay),  32'(ey));
      check({nm, ".visible"},     32'(av),  32'(ev));
      check({nm, ".hsync"},       32'(ah),  32'(eh));
      check({nm, ".vsync"},       32'(avs), 32'(evs));
      check({nm, ".pix_en"},      32'(ape), 32'(epe));
      check({nm, ".frame_start"}, 32'(afs), 32'(efs));
   endtask

   task automatic check_all();
      model_check("dflt",  640, 480, d_x, d_y, d_vis, d_hs, d_vs, d_pe, d_fs);
      model_check("small", SHA, SVA, s_x, s_y, s_vis, s_hs, s_vs, s_pe, s_fs);
   endtask

   // Advance k clk edges, checking both instances at each falling edge
   task automatic run(input int k);
      repeat (k) begin
         @(posedge clk);
         if (!rst) n++;
         @(negedge clk);
         check_all();
      end
   endtask

   // Assert reset away from the active edge and check it clears at once
   task automatic async_reset(input int hold);
      #($urandom_range(1, 8));
      rst = 1'b1;
      n   = 0;
      #1;
      check_all();
      run(hold);
      @(negedge clk);
      #($urandom_range(1, 8));
      rst = 1'b0;
   endtask

   initial begin
      int guard;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_all();
      #2 rst = 1'b0;

      // Past the first wrap of the reduced raster's frame (23744 clk)
      run(24000);

      // Reset landing inside the default instance's hsync pulse
      guard = 0;
      while ((((n / 2) % (800 * 525)) % 800) != 700 && guard < 2000) begin
         run(1);
         guard++;
      end
      check("x700_reached", 32'(guard < 2000), 32'd1);
      @(negedge clk);
      async_reset(3);
      run(2000);

      for (int seg = 0; seg < 10; seg++) begin
         run($urandom_range(200, 3000));
         @(negedge clk);
         async_reset($urandom_range(1, 4));
      end
      run(400);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-003 clk  input  1  system clock, 50 MHz; all logic in this single clock domain.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 x  output  10  current horizontal pixel position (horizontal count).
REQ-006 y  output  10  current line position (vertical count).
REQ-007 visible  output  1  high while (x,y) is inside the active area.
REQ-008 hsync  output  1  horizontal sync, active-low.
REQ-009 vsync  output  1  vertical sync, active-low.
REQ-010 pix_en  output  1  pixel-rate enable, one clk cycle wide; also drives the DAC pixel clock.
REQ-011 frame_start  output  1  single-clk pulse marking pixel (0,0) of each frame.

Function
REQ-012 pix_en SHALL toggle every clk cycle, giving 25 MHz; first high in the second clk cycle after reset release.
REQ-013 hcount SHALL advance by 1 only in cycles with pix_en=1 and wrap from H_TOTAL-1 (799) to 0.
REQ-014 vcount SHALL advance by 1 only when hcount wraps, and wrap from V_TOTAL-1 (524) to 0 in the same cycle hcount wraps.
REQ-015 Horizontal timing: active 640, front porch 16, sync 96, back porch 48, total 800.
REQ-016 Vertical timing: active 480, front porch 10, sync 2, back porch 33, total 525.
REQ-017 x and y SHALL equal hcount and vcount; visible, hsync and vsync SHALL be registered and decoded from the next counter values, so all five outputs change in the same clk edge with zero relative skew.
REQ-018 visible=1 exactly when x<H_ACTIVE and y<V_ACTIVE.
REQ-019 hsync=0 exactly when 656<=x<=751; vsync=0 exactly when 490<=y<=491.
REQ-020 frame_start=1 for exactly one clk cycle: the first cycle in which x=0, y=0 holds after a vcount wrap; never during or directly after reset.
REQ-021 Outputs SHALL hold stable between pix_en pulses; downstream pixel generators sample on pix_en.
REQ-022 x and y SHALL never exceed 799 and 524 respectively; out-of-range values are unreachable.

Reset
REQ-023 While rst=1: hcount=0, vcount=0, pix_en=0, visible=0, hsync=1, vsync=1, frame_start=0.
REQ-024 rst assertion mid-line or mid-frame SHALL clear all state immediately (asynchronous), with no partial sync pulse completion.
REQ-025 After release, the first pix_en advances to x=1, y=0, visible=1; pixel (0,0) of the first frame only is blanked.

Structure
REQ-026 Package vga_pkg SHALL hold all porch/sync/total constants, counter width (10) and sync polarity constant.
REQ-027 One sub-module, wrap_counter (parameterised max, enable in, wrap out), SHALL be instantiated twice for hcount and vcount.
REQ-028 All state elements SHALL use async active-high reset; no latches, no derived clocks (pix_en is an enable only).

Verification
REQ-029 Release reset, run 2*800 clk -> pix_en alternates 0,1; x goes 1..799,0; y increments to 1 exactly at x wrap.
REQ-030 Run one full frame (2*800*525 = 840000 clk) -> frame_start pulses once, one clk wide, at x=0,y=0; next pulse 840000 clk later.
REQ-031 Check line 0 -> hsync low for exactly 96 pix_en cycles starting at x=656; visible high for x=0..639 only.
REQ-032 Check vertical -> vsync low for exactly 2 lines (1600 pix_en) starting at y=490,x=0; visible low for all y>=480.
REQ-033 Assert rst at x=700 (inside hsync) for 3 clk -> hsync=1, x=y=0, visible=0 immediately; restart per REQ-025.
REQ-034 Connect pixel generator fed by x,y,visible -> RGB zero whenever visible=0 across a full frame; no x/y/visible skew assertion failures.
